// File: rtl/qspi_sram_pkg.sv
// Shared definitions for the quad-SPI serial SRAM responder.
// Opcodes, phase lengths and the protocol state encoding.
package qspi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam int CMD_NIBBLES  = 2;
  localparam int ADDR_NIBBLES = 6;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    IGNORE
  } state_t;

endpackage

// File: rtl/qspi_pin_sync.sv
// Synchronizers for cs_n/sck/sio plus one-clk sck edge pulses.
// cs_n resets to "selected" so a fresh deselect is needed after reset.
module qspi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n_i,
  input  logic       sck_i,
  input  logic [3:0] sio_i,
  output logic       cs_n_o,
  output logic [3:0] sio_o,
  output logic       sck_rise_o,
  output logic       sck_fall_o
);

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sck_q;
  logic [3:0]             sio_q [SYNC_STAGES];
  logic                   sck_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q       <= '0;
      sck_q      <= '0;
      sck_prev_q <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sio_q[i] <= '0;
    end else begin
      cs_q[0]    <= cs_n_i;
      sck_q[0]   <= sck_i;
      sio_q[0]   <= sio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_q[i]  <= cs_q[i-1];
        sck_q[i] <= sck_q[i-1];
        sio_q[i] <= sio_q[i-1];
      end
      sck_prev_q <= sck_q[SYNC_STAGES-1];
    end
  end

  assign cs_n_o     = cs_q[SYNC_STAGES-1];
  assign sio_o      = sio_q[SYNC_STAGES-1];
  assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[SYNC_STAGES-1] & sck_prev_q;

endmodule

// File: rtl/qspi_sram_responder.sv
// Quad-SPI serial SRAM target backed by an internal byte array.
// sck is oversampled on clk; sio is sampled on rise, driven on fall.
module qspi_sram_responder
  import qspi_sram_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 16,
  parameter int    DUMMY_CYCLES = 2,
  parameter int    SYNC_STAGES  = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sck,
  input  logic [3:0] sio_i,
  output logic [3:0] sio_o,
  output logic       sio_oe
);

  logic                  cs_s, rise, fall;
  logic [3:0]            sio_s;
  state_t                state_q;
  logic [7:0]            cnt_q;
  logic [3:0]            sh_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q, lo_q, armed_q, we_q;
  logic [7:0]            wdata_q, rd_q;
  logic [3:0]            sio_o_q;
  logic                  sio_oe_q;
  logic [7:0]            mem_q [2**ADDR_WIDTH];

  qspi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .cs_n_i    (cs_n),
    .sck_i     (sck),
    .sio_i     (sio_i),
    .cs_n_o    (cs_s),
    .sio_o     (sio_s),
    .sck_rise_o(rise),
    .sck_fall_o(fall)
  );

  // Single-port RAM; rd_q continuously tracks mem[addr_q] as prefetch
  always_ff @(posedge clk) begin
    if (we_q)
      mem_q[addr_q] <= wdata_q;
    rd_q <= mem_q[addr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      lo_q     <= 1'b0;
      armed_q  <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      sio_o_q  <= '0;
      sio_oe_q <= 1'b0;
    end else if (cs_s) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      lo_q     <= 1'b0;
      armed_q  <= 1'b1;
      we_q     <= 1'b0;
      sio_o_q  <= '0;
      sio_oe_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q)
        addr_q <= addr_q + ADDR_WIDTH'(1);
      unique case (state_q)
        IDLE: if (armed_q) begin
          state_q <= CMD;
          cnt_q   <= '0;
        end
        CMD: if (rise) begin
          sh_q  <= sio_s;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(CMD_NIBBLES - 1)) begin
            cnt_q <= '0;
            wr_q  <= ({sh_q, sio_s} == OP_WRITE);
            if ({sh_q, sio_s} == OP_READ ||
                {sh_q, sio_s} == OP_WRITE)
              state_q <= ADDR;
            else
              state_q <= IGNORE;
          end
        end
        ADDR: if (rise) begin
          addr_q <= {addr_q[ADDR_WIDTH-5:0], sio_s};
          cnt_q  <= cnt_q + 8'd1;
          if (cnt_q == 8'(ADDR_NIBBLES - 1)) begin
            cnt_q   <= '0;
            lo_q    <= 1'b0;
            state_q <= wr_q ? WDATA : DUMMY;
          end
        end
        DUMMY: begin
          if (rise && cnt_q != 8'(DUMMY_CYCLES))
            cnt_q <= cnt_q + 8'd1;
          if (fall && cnt_q == 8'(DUMMY_CYCLES)) begin
            sio_oe_q <= 1'b1;
            sio_o_q  <= rd_q[7:4];
            lo_q     <= 1'b1;
            state_q  <= RDATA;
          end
        end
        RDATA: if (fall) begin
          if (lo_q) begin
            sio_o_q <= rd_q[3:0];
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            lo_q    <= 1'b0;
          end else begin
            sio_o_q <= rd_q[7:4];
            lo_q    <= 1'b1;
          end
        end
        WDATA: if (rise) begin
          if (lo_q) begin
            we_q    <= 1'b1;
            wdata_q <= {sh_q, sio_s};
            lo_q    <= 1'b0;
          end else begin
            sh_q <= sio_s;
            lo_q <= 1'b1;
          end
        end
        IGNORE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sio_o  = sio_o_q;
  assign sio_oe = sio_oe_q;

endmodule
